bus_mailbox_slave: RTL and testbench

BUS_MAILBOX_SLAVE -- requirements
Module: bus_mailbox_slave

---
 rtl/bus_mailbox_pkg.sv | 37 +++
 rtl/mailbox_fifo.sv | 63 ++++++
 rtl/bus_mailbox_slave.sv | 137 +++++++++++++
 tb/tb_bus_mailbox_slave.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_mailbox_pkg.sv
// Shared register map, STATUS bit layout and FSM encoding for the bus mailbox.
// Optional feature macro: MAILBOX_IRQ_EN (see bus_mailbox_slave).
package bus_mailbox_pkg;

   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_CTRL   = 2'd2;
   localparam logic [1:0] REG_THRESH = 2'd3;

   localparam int unsigned ST_EMPTY     = 0;
   localparam int unsigned ST_FULL      = 1;
   localparam int unsigned ST_OVF       = 2;
   localparam int unsigned ST_UNF       = 3;
   localparam int unsigned ST_COUNT_LSB = 16;

   localparam int unsigned CTRL_FLUSH = 0;
   localparam int unsigned CTRL_CLR   = 1;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_FLUSH = 1'b1
   } mbox_state_e;

   function automatic logic [31:0] pack_status(input logic [15:0] cnt, input logic unf,
                                               input logic ovf, input logic full,
                                               input logic empty);
      logic [31:0] s;
      s                          = '0;
      s[ST_COUNT_LSB +: 16]      = cnt;
      s[ST_UNF]                  = unf;
      s[ST_OVF]                  = ovf;
      s[ST_FULL]                 = full;
      s[ST_EMPTY]                = empty;
      return s;
   endfunction

endpackage

// File: rtl/mailbox_fifo.sv
// Circular-buffer FIFO for the mailbox: push, pop and flush-one (a pop that discards).
// Overflowing pushes and underflowing pops are ignored here; the caller flags them.
module mailbox_fifo #(
   parameter  int unsigned DEPTH = 16,
   parameter  int unsigned DW    = 32,
   localparam int unsigned AW    = $clog2(DEPTH),
   localparam int unsigned CW    = AW + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic          flush_i,
   input  logic [DW-1:0] wdata_i,
   output logic [DW-1:0] head_o,
   output logic [CW-1:0] count_o,
   output logic [CW-1:0] count_next_o,
   output logic          full_o,
   output logic          empty_o
);

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i & ~full_o;
   assign do_pop  = (pop_i | flush_i) & ~empty_o;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (do_push) wptr_d = wptr_q + AW'(1);
      if (do_pop)  rptr_d = rptr_q + AW'(1);
      if (do_push && !do_pop)      count_d = count_q + CW'(1);
      else if (do_pop && !do_push) count_d = count_q - CW'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Storage is not reset: validity is tracked solely by the pointers and count.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= wdata_i;
   end

   assign head_o       = mem_q[rptr_q];
   assign count_o      = count_q;
   assign count_next_o = count_d;

endmodule

// File: rtl/bus_mailbox_slave.sv
// Memory-mapped mailbox slave: DATA/STATUS/CTRL/THRESH window over a FIFO with flush FSM.
// Define MAILBOX_IRQ_EN to enable the THRESH register and the level interrupt.
module bus_mailbox_slave
   import bus_mailbox_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0004_0000,
   parameter int unsigned DEPTH     = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rreq,
   input  logic        wreq,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ack,
   output logic        busy,
   output logic        irq
);

   localparam int unsigned TW = $clog2(DEPTH) + 1;

   mbox_state_e   state_q, state_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          ovf_q, ovf_d, unf_q, unf_d;
   logic          beat, wr_beat, rd_beat;
   logic [1:0]    off;
   logic          push, pop, flush_one;
   logic [31:0]   head;
   logic [TW-1:0] count, count_next, thresh_rd;
   logic          full, empty;

   // ack is held low during reset so every output reads 0 while reset is asserted.
   assign ack       = reset & (rreq | wreq) & (addr[31:4] == BASE_ADDR[31:4]);
   assign beat      = ack & (state_q == S_IDLE);
   assign wr_beat   = beat & wreq;
   assign rd_beat   = beat & rreq & ~wreq;
   assign off       = addr[3:2];
   assign push      = wr_beat & (off == REG_DATA);
   assign pop       = rd_beat & (off == REG_DATA);
   assign flush_one = (state_q == S_FLUSH);
   assign busy      = (state_q == S_FLUSH);
   assign rdata     = rdata_q;

   mailbox_fifo #(
      .DEPTH (DEPTH),
      .DW    (32)
   ) u_fifo (
      .clk          (clk),
      .reset        (reset),
      .push_i       (push),
      .pop_i        (pop),
      .flush_i      (flush_one),
      .wdata_i      (wdata),
      .head_o       (head),
      .count_o      (count),
      .count_next_o (count_next),
      .full_o       (full),
      .empty_o      (empty)
   );

   always_comb begin
      state_d = state_q;
      rdata_d = rdata_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      case (state_q)
         S_IDLE:  if (wr_beat && off == REG_CTRL && wdata[CTRL_FLUSH]) state_d = S_FLUSH;
         // Leave once this cycle's discard empties the FIFO (or it was already empty).
         S_FLUSH: if (count <= TW'(1)) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (push && full)  ovf_d = 1'b1;
      if (pop && empty)  unf_d = 1'b1;
      if (wr_beat && off == REG_CTRL && wdata[CTRL_CLR]) begin
         ovf_d = 1'b0;
         unf_d = 1'b0;
      end
      if (rd_beat) begin
         case (off)
            REG_DATA:   rdata_d = empty ? '0 : head;
            REG_STATUS: rdata_d = pack_status(16'(count), unf_q, ovf_q, full, empty);
            REG_THRESH: rdata_d = 32'(thresh_rd);
            default:    rdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         rdata_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rdata_q <= rdata_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

`ifdef MAILBOX_IRQ_EN
   logic [TW-1:0] thresh_q, thresh_d;
   logic          irq_q, irq_d;

   always_comb begin
      thresh_d = thresh_q;
      if (wr_beat && off == REG_THRESH) thresh_d = wdata[TW-1:0];
   end

   // Evaluated on next-state values so irq tracks the registered state without extra lag.
   assign irq_d = ((thresh_d != '0) && (count_next >= thresh_d)) || ovf_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         thresh_q <= '0;
         irq_q    <= 1'b0;
      end else begin
         thresh_q <= thresh_d;
         irq_q    <= irq_d;
      end
   end

   assign irq       = irq_q;
   assign thresh_rd = thresh_q;
`else
   logic unused_count_next;
   assign unused_count_next = ^count_next;
   assign irq       = 1'b0;
   assign thresh_rd = '0;
`endif

   logic unused_addr;
   assign unused_addr = ^addr[1:0];

endmodule

// File: tb/tb_bus_mailbox_slave.sv
// Self-checking bench for bus_mailbox_slave: directed vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_bus_mailbox_slave;

   localparam logic [31:0] BASE  = 32'h0004_0000;
   localparam int          DEPTH = 16;
   localparam int          TW    = $clog2(DEPTH) + 1;
`ifdef MAILBOX_IRQ_EN
   localparam bit IRQ_EN = 1'b1;
`else
   localparam bit IRQ_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset, rreq, wreq;
   logic [31:0] addr, wdata, rdata;
   logic        ack, busy, irq;

   bus_mailbox_slave #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .rreq  (rreq),
      .wreq  (wreq),
      .addr  (addr),
      .wdata (wdata),
      .rdata (rdata),
      .ack   (ack),
      .busy  (busy),
      .irq   (irq)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: FIFO as a queue, flush as a countdown of remaining busy cycles.
   logic [31:0] mq[$];
   bit          m_ovf, m_unf, m_irq;
   int          m_thresh, m_busy_n;
   logic [31:0] m_rdata;

   function automatic void model_reset();
      mq.delete();
      m_ovf = 0; m_unf = 0; m_irq = 0;
      m_thresh = 0; m_busy_n = 0; m_rdata = '0;
   endfunction

   function automatic logic [31:0] m_status();
      int n = mq.size();
      return (n << 16) | (int'(m_unf) << 3) | (int'(m_ovf) << 2)
             | (int'(n == DEPTH) << 1) | int'(n == 0);
   endfunction

   function automatic void model_step(input logic r, input logic w, input logic [31:0] a,
                                      input logic [31:0] d);
      bit hit = (r | w) && (a[31:4] == BASE[31:4]);
      int off = int'(a[3:2]);
      if (m_busy_n > 0) begin
         if (mq.size() > 0) void'(mq.pop_front());
         m_busy_n--;
      end else if (hit && w) begin
         if (off == 0) begin
            if (mq.size() == DEPTH) m_ovf = 1;
            else mq.push_back(d);
         end else if (off == 2) begin
            if (d[1]) begin m_ovf = 0; m_unf = 0; end
            if (d[0]) m_busy_n = (mq.size() == 0) ? 1 : mq.size();
         end else if (off == 3 && IRQ_EN) begin
            m_thresh = int'(d[TW-1:0]);
         end
      end else if (hit) begin
         case (off)
            0: if (mq.size() == 0) begin m_rdata = '0; m_unf = 1; end
               else m_rdata = mq.pop_front();
            1: m_rdata = m_status();
            2: m_rdata = '0;
            default: m_rdata = IRQ_EN ? 32'(m_thresh) : '0;
         endcase
      end
      m_irq = IRQ_EN && (((m_thresh != 0) && (mq.size() >= m_thresh)) || m_ovf);
   endfunction

   task automatic drive(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, output logic ack_seen);
      logic exp_ack;
      @(negedge clk);
      rreq = r; wreq = w; addr = a; wdata = d;
      #1;
      ack_seen = ack;
      exp_ack  = (r | w) && (a[31:4] == BASE[31:4]);
      check("ack", ack, exp_ack);
      @(posedge clk);
      model_step(r, w, a, d);
      #1;
      check("rdata", rdata, m_rdata);
      check("busy", busy, m_busy_n > 0);
      check("irq", irq, m_irq);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("rst_rdata", rdata, 32'h0);
      check("rst_busy", busy, 1'b0);
      check("rst_irq", irq, 1'b0);
      check("rst_ack", ack, 1'b0);
      model_reset();
      rreq = 0; wreq = 0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   typedef struct {
      logic        r, w;
      logic [31:0] a, d, exp_rdata;
      logic        exp_ack;
   } vec_t;

   vec_t tbl[13];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic a_s;
      int   bc;
      reset = 1'b0; rreq = 0; wreq = 0; addr = '0; wdata = '0;
      model_reset();
      repeat (2) @(negedge clk);
      check("reset_rdata", rdata, 32'h0);
      check("reset_busy", busy, 1'b0);
      check("reset_irq", irq, 1'b0);
      reset = 1'b1;

      tbl[0]  = '{0, 1, BASE + 0,  32'd1, 32'h0,         1'b1};
      tbl[1]  = '{0, 1, BASE + 0,  32'd2, 32'h0,         1'b1};
      tbl[2]  = '{0, 1, BASE + 0,  32'd3, 32'h0,         1'b1};
      tbl[3]  = '{0, 1, BASE + 0,  32'd4, 32'h0,         1'b1};
      tbl[4]  = '{1, 0, BASE + 4,  32'd0, 32'h0004_0000, 1'b1};
      tbl[5]  = '{1, 0, BASE + 0,  32'd0, 32'd1,         1'b1};
      tbl[6]  = '{1, 0, BASE + 2,  32'd0, 32'd2,         1'b1};
      tbl[7]  = '{1, 0, BASE + 1,  32'd0, 32'd3,         1'b1};
      tbl[8]  = '{1, 0, BASE + 3,  32'd0, 32'd4,         1'b1};
      tbl[9]  = '{1, 0, BASE + 4,  32'd0, 32'h0000_0001, 1'b1};
      tbl[10] = '{1, 0, BASE + 16, 32'd0, 32'h0000_0001, 1'b0};
      tbl[11] = '{1, 0, BASE + 8,  32'd0, 32'h0,         1'b1};
      tbl[12] = '{1, 0, BASE + 12, 32'd0, 32'h0,         1'b1};
      for (int i = 0; i < 13; i++) begin
         drive(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, a_s);
         check($sformatf("tbl%0d_ack", i), a_s, tbl[i].exp_ack);
         check($sformatf("tbl%0d_rdata", i), rdata, tbl[i].exp_rdata);
      end

      // Overflow: DEPTH+1 pushes, last dropped; CTRL bit1 clears the sticky flag.
      for (int i = 0; i <= DEPTH; i++) drive(0, 1, BASE, 32'hA000 + i, a_s);
      drive(1, 0, BASE + 4, 0, a_s);
      check("ovf_status", rdata, 32'h0010_0006);
      drive(0, 1, BASE + 8, 32'd2, a_s);
      drive(1, 0, BASE + 4, 0, a_s);
      check("ovf_cleared", rdata, 32'h0010_0002);

      // Reset in the middle of a write burst.
      drive(0, 1, BASE, 32'hDEAD, a_s);
      do_reset();
      drive(1, 0, BASE + 4, 0, a_s);
      check("post_reset_status", rdata, 32'h0000_0001);

      // Flush of 5 entries: busy for exactly 5 cycles, beats during busy ignored.
      for (int i = 0; i < 5; i++) drive(0, 1, BASE, 32'hB0 + i, a_s);
      drive(0, 1, BASE + 8, 32'd1, a_s);
      bc = busy ? 1 : 0;
      for (int k = 0; k < 20; k++) begin
         drive(0, 1, BASE, $urandom, a_s);
         if (busy) bc++;
         else break;
      end
      check("flush_cycles", bc, 32'd5);
      drive(1, 0, BASE + 4, 0, a_s);
      check("flush_status", rdata, 32'h0000_0001);

      // Flush of an empty FIFO: one busy cycle.
      drive(0, 1, BASE + 8, 32'd1, a_s);
      check("eflush_busy", busy, 1'b1);
      drive(0, 0, 0, 0, a_s);
      check("eflush_idle", busy, 1'b0);

      // Pop on empty sets UNF and returns 0.
      drive(1, 0, BASE, 0, a_s);
      check("unf_rdata", rdata, 32'h0);
      drive(1, 0, BASE + 4, 0, a_s);
      check("unf_status", rdata, 32'h0000_0009);
      drive(0, 1, BASE + 8, 32'd2, a_s);

`ifdef MAILBOX_IRQ_EN
      drive(0, 1, BASE + 12, 32'd3, a_s);
      drive(0, 1, BASE, 32'h11, a_s);
      drive(0, 1, BASE, 32'h22, a_s);
      check("irq_two", irq, 1'b0);
      drive(0, 1, BASE, 32'h33, a_s);
      check("irq_three", irq, 1'b1);
      drive(1, 0, BASE, 0, a_s);
      check("irq_pop", irq, 1'b0);
      drive(1, 0, BASE + 12, 0, a_s);
      check("thresh_rd", rdata, 32'd3);
      do_reset();
`endif

      // Randomized traffic against the model.
      for (int n = 0; n < 600; n++) begin
         int          sel;
         logic        r, w;
         logic [31:0] a, d;
         sel = $urandom_range(0, 99);
         r = 0; w = 0; d = $urandom;
         a = BASE | 32'($urandom_range(0, 3));
         if (sel < 40)      begin w = 1; r = 1'($urandom_range(0, 1)); end
         else if (sel < 75) r = 1;
         else if (sel < 85) begin r = 1; a = a + 4; end
         else if (sel < 88) begin w = 1; a = a + 8; d = 32'($urandom_range(0, 3)); end
         else if (sel < 91) begin w = 1; a = a + 12; d = 32'($urandom_range(0, 8)); end
         else if (sel < 94) begin r = 1; a = a + 8 + 4 * 32'($urandom_range(0, 1)); end
         else if (sel < 97) begin r = 1; a = BASE + 16 * 32'($urandom_range(1, 100)); end
         drive(r, w, a, d, a_s);
      end

      rreq = 0; wreq = 0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
